// File: rtl/mul_rs.sv
// mul_rs - reservation station in front of the pipelined multiply unit.
//
// Holds issued multiply instructions until both operands are available.
// While an entry waits, it snoops the CDB for the operands it still needs.
// The lowest-index ready entry is offered to the multiply unit.
//
// Ports
//   clk           rising-edge clock
//   RST           synchronous active-high reset
//   issueEN       issue request (one cycle)
//   issueVj/Qj    operand 1 value / producer tag (tag 0 = value valid)
//   issueVk/Qk    operand 2 value / producer tag
//   issueTag      tag the next issued entry receives, 0 when full
//   full          no free entry; issueEN ignored
//   cdbValid      CDB broadcast valid
//   cdbTag        CDB tag
//   cdbData       CDB value
//   aluAvailable  multiply unit accepts a dispatch this cycle
//   dispatchReq   a ready entry exists (drives the unit's inEN)
//   dispatchOp1   operand 1 of the selected entry, 0 when idle
//   dispatchOp2   operand 2 of the selected entry, 0 when idle
//   dispatchTag   tag of the selected entry, 0 when idle
module mul_rs #(
  parameter int DEPTH    = 3,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             issueEN,
  input  logic [31:0]      issueVj,
  input  logic [TAG_W-1:0] issueQj,
  input  logic [31:0]      issueVk,
  input  logic [TAG_W-1:0] issueQk,
  output logic [TAG_W-1:0] issueTag,
  output logic             full,
  input  logic             cdbValid,
  input  logic [TAG_W-1:0] cdbTag,
  input  logic [31:0]      cdbData,
  input  logic             aluAvailable,
  output logic             dispatchReq,
  output logic [31:0]      dispatchOp1,
  output logic [31:0]      dispatchOp2,
  output logic [TAG_W-1:0] dispatchTag
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy;
  logic [DATA_W-1:0] vj [DEPTH];
  logic [TAG_W-1:0]  qj [DEPTH];
  logic [DATA_W-1:0] vk [DEPTH];
  logic [TAG_W-1:0]  qk [DEPTH];

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             issue_fire;
  logic             dispatch_fire;

  // Tag 0 means "no dependency", so it must never match a broadcast.
  function automatic logic cdb_hit(input logic             valid,
                                   input logic [TAG_W-1:0] btag,
                                   input logic [TAG_W-1:0] q);
    return valid && (q != '0) && (q == btag);
  endfunction

  function automatic logic [TAG_W-1:0] entry_tag(input logic [IDX_W-1:0] idx);
    return TAG_W'(TAG_BASE) + TAG_W'(idx);
  endfunction

  // Free-slot search uses registered busy only, so a slot freed by a
  // dispatch this cycle becomes visible to issue in the next cycle.
  always_comb begin
    full     = 1'b1;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        full     = 1'b0;
        free_idx = IDX_W'(i);
      end
    end
    issueTag = full ? '0 : entry_tag(free_idx);
  end

  // Lowest-index ready entry wins; outputs stay zero when nothing is ready.
  always_comb begin
    dispatchReq = 1'b0;
    sel_idx     = '0;
    dispatchOp1 = '0;
    dispatchOp2 = '0;
    dispatchTag = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (busy[i] && (qj[i] == '0) && (qk[i] == '0)) begin
        dispatchReq = 1'b1;
        sel_idx     = IDX_W'(i);
        dispatchOp1 = vj[i];
        dispatchOp2 = vk[i];
        dispatchTag = entry_tag(IDX_W'(i));
      end
    end
  end

  assign issue_fire    = issueEN && !full;
  assign dispatch_fire = dispatchReq && aluAvailable;

  // Entry update: CDB capture, dispatch release and issue write are
  // independent. The issued slot is always non-busy, so it can never be
  // the one being dispatched or snooping in the same cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        vj[i] <= '0;
        qj[i] <= '0;
        vk[i] <= '0;
        qk[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i]) begin
          if (cdb_hit(cdbValid, cdbTag, qj[i])) begin
            vj[i] <= cdbData;
            qj[i] <= '0;
          end
          if (cdb_hit(cdbValid, cdbTag, qk[i])) begin
            vk[i] <= cdbData;
            qk[i] <= '0;
          end
        end
        if (dispatch_fire && (sel_idx == IDX_W'(i))) begin
          busy[i] <= 1'b0;
        end
        if (issue_fire && (free_idx == IDX_W'(i))) begin
          busy[i] <= 1'b1;
          // A producer broadcasting in the issue cycle is captured directly.
          if (cdb_hit(cdbValid, cdbTag, issueQj)) begin
            vj[i] <= cdbData;
            qj[i] <= '0;
          end else begin
            vj[i] <= issueVj;
            qj[i] <= issueQj;
          end
          if (cdb_hit(cdbValid, cdbTag, issueQk)) begin
            vk[i] <= cdbData;
            qk[i] <= '0;
          end else begin
            vk[i] <= issueVk;
            qk[i] <= issueQk;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_rs.sv
// tb_mul_rs - directed bench for mul_rs (DEPTH=3, TAG_W=4, TAG_BASE=1).
module tb_mul_rs;

  logic        clk = 1'b0;
  logic        RST;
  logic        issueEN;
  logic [31:0] issueVj;
  logic [3:0]  issueQj;
  logic [31:0] issueVk;
  logic [3:0]  issueQk;
  logic [3:0]  issueTag;
  logic        full;
  logic        cdbValid;
  logic [3:0]  cdbTag;
  logic [31:0] cdbData;
  logic        aluAvailable;
  logic        dispatchReq;
  logic [31:0] dispatchOp1;
  logic [31:0] dispatchOp2;
  logic [3:0]  dispatchTag;

  int n_checks = 0;
  int n_err    = 0;

  mul_rs #(.DEPTH(3), .TAG_W(4), .TAG_BASE(1)) dut (
    .clk(clk), .RST(RST),
    .issueEN(issueEN), .issueVj(issueVj), .issueQj(issueQj),
    .issueVk(issueVk), .issueQk(issueQk), .issueTag(issueTag), .full(full),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
    .aluAvailable(aluAvailable), .dispatchReq(dispatchReq),
    .dispatchOp1(dispatchOp1), .dispatchOp2(dispatchOp2),
    .dispatchTag(dispatchTag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] vj, input logic [3:0] qj,
                       input logic [31:0] vk, input logic [3:0] qk);
    issueEN = 1'b1;
    issueVj = vj;
    issueQj = qj;
    issueVk = vk;
    issueQk = qk;
  endtask

  task automatic idle_in();
    issueEN  = 1'b0;
    issueVj  = '0;
    issueQj  = '0;
    issueVk  = '0;
    issueQk  = '0;
    cdbValid = 1'b0;
    cdbTag   = '0;
    cdbData  = '0;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    cdbValid = 1'b1;
    cdbTag   = t;
    cdbData  = d;
  endtask

  initial begin
    RST = 1'b1;
    aluAvailable = 1'b0;
    idle_in();
    step();
    step();
    RST = 1'b0;

    // Reset state
    chk("rst_full", full, 0);
    chk("rst_req", dispatchReq, 0);
    chk("rst_op1", dispatchOp1, 0);
    chk("rst_op2", dispatchOp2, 0);
    chk("rst_dtag", dispatchTag, 0);
    chk("rst_itag", issueTag, 1);

    // Ready issue -> dispatch next cycle
    aluAvailable = 1'b1;
    issue(32'd3, 4'd0, 32'd5, 4'd0);
    chk("t1_itag", issueTag, 1);
    chk("t1_req_issuecyc", dispatchReq, 0);
    step();
    idle_in();
    chk("t1_req", dispatchReq, 1);
    chk("t1_op1", dispatchOp1, 3);
    chk("t1_op2", dispatchOp2, 5);
    chk("t1_dtag", dispatchTag, 1);
    step();
    chk("t1_req_after", dispatchReq, 0);
    chk("t1_full_after", full, 0);

    // Wait on tag 6, broadcast two cycles later
    issue(32'd0, 4'd6, 32'd7, 4'd0);
    step();
    idle_in();
    chk("t2_req_w0", dispatchReq, 0);
    step();
    chk("t2_req_w1", dispatchReq, 0);
    cdb(4'd6, 32'h10);
    chk("t2_req_bcast", dispatchReq, 0);
    step();
    idle_in();
    chk("t2_req", dispatchReq, 1);
    chk("t2_op1", dispatchOp1, 32'h10);
    chk("t2_op2", dispatchOp2, 7);
    chk("t2_dtag", dispatchTag, 1);
    step();
    chk("t2_req_after", dispatchReq, 0);

    // Issue with same-cycle CDB on Qk
    issue(32'h22, 4'd0, 32'd0, 4'd5);
    cdb(4'd5, 32'hAB);
    step();
    idle_in();
    chk("t3_req", dispatchReq, 1);
    chk("t3_op1", dispatchOp1, 32'h22);
    chk("t3_op2", dispatchOp2, 32'hAB);
    step();
    chk("t3_req_after", dispatchReq, 0);

    // Fill with unit stalled, drop a fourth issue, then drain
    aluAvailable = 1'b0;
    issue(32'd1, 4'd0, 32'd2, 4'd0);
    chk("t4_itag0", issueTag, 1);
    step();
    issue(32'd3, 4'd0, 32'd4, 4'd0);
    chk("t4_itag1", issueTag, 2);
    step();
    issue(32'd5, 4'd0, 32'd6, 4'd0);
    chk("t4_itag2", issueTag, 3);
    step();
    chk("t4_full", full, 1);
    chk("t4_itag_full", issueTag, 0);
    issue(32'd9, 4'd0, 32'd9, 4'd0);
    step();
    idle_in();
    chk("t4_full_drop", full, 1);
    chk("t4_sel_stall", dispatchTag, 1);
    chk("t4_op1_stall", dispatchOp1, 1);
    aluAvailable = 1'b1;
    step();
    chk("t4_full_drain", full, 0);
    chk("t4_itag_drain", issueTag, 1);
    chk("t4_dtag2", dispatchTag, 2);
    chk("t4_op1_2", dispatchOp1, 3);
    step();
    chk("t4_dtag3", dispatchTag, 3);
    chk("t4_op1_3", dispatchOp1, 5);
    step();
    chk("t4_req_empty", dispatchReq, 0);
    chk("t4_full_empty", full, 0);

    // Out-of-order: entry 0 waits on tag 7, entry 1 ready
    issue(32'd0, 4'd7, 32'h11, 4'd0);
    step();
    issue(32'h21, 4'd0, 32'h22, 4'd0);
    chk("t5_itag", issueTag, 2);
    step();
    idle_in();
    chk("t5_req", dispatchReq, 1);
    chk("t5_dtag_first", dispatchTag, 2);
    chk("t5_op1_first", dispatchOp1, 32'h21);
    cdb(4'd7, 32'h77);
    step();
    idle_in();
    chk("t5_dtag_second", dispatchTag, 1);
    chk("t5_op1_second", dispatchOp1, 32'h77);
    chk("t5_op2_second", dispatchOp2, 32'h11);
    step();
    chk("t5_req_after", dispatchReq, 0);

    // Reset with two busy entries and a broadcast pending
    aluAvailable = 1'b0;
    issue(32'd0, 4'd9, 32'd1, 4'd0);
    step();
    issue(32'd0, 4'd9, 32'd2, 4'd0);
    step();
    idle_in();
    chk("t6_itag_busy", issueTag, 3);
    RST = 1'b1;
    cdb(4'd9, 32'h99);
    step();
    RST = 1'b0;
    idle_in();
    chk("t6_full", full, 0);
    chk("t6_req", dispatchReq, 0);
    chk("t6_op1", dispatchOp1, 0);
    chk("t6_op2", dispatchOp2, 0);
    chk("t6_dtag", dispatchTag, 0);
    chk("t6_itag", issueTag, 1);
    aluAvailable = 1'b1;
    cdb(4'd9, 32'h99);
    step();
    idle_in();
    chk("t6_late_cdb_req", dispatchReq, 0);
    chk("t6_late_cdb_itag", issueTag, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
